// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam int OPC_W = 4;
  localparam logic [OPC_W-1:0] OPC_NOP = 4'b0000;

  // Bit position of the opcode MSB for a given instruction width.
  function automatic int opc_msb(input int instr_w);
    return instr_w - 1;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// holds the fetched word for decode and squashes fetches made stale by redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 32,
  parameter int RESET_PC = 0
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  output logic               out_imem_req,
  output logic [ADDR_W-1:0]  out_imem_addr,
  input  logic               in_imem_ack,
  input  logic [INSTR_W-1:0] in_imem_data,
  output logic               out_instr_valid,
  input  logic               in_dec_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               in_redirect,
  input  logic [ADDR_W-1:0]  in_redirect_pc,
  output fetch_state_t       out_dbg_state
);

  localparam int OPC_MSB = opc_msb(INSTR_W);

  // Handshakes: imem transfers when out_imem_req && in_imem_ack in the same
  // cycle (ack is a one-cycle pulse, address held until then); decode takes
  // the held word when out_instr_valid && in_dec_ready on a rising edge.

  fetch_state_t       state_q, state_d;
  logic               run_q;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pc_next_q, pc_next_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic               valid_q, valid_d;

  // run_q keeps req low while reset is held and for the release half-cycle.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q   <= FETCH;
      run_q     <= 1'b0;
      pc_q      <= ADDR_W'(RESET_PC);
      pc_next_q <= '0;
      instr_q   <= '0;
      out_pc_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
      instr_q   <= instr_d;
      out_pc_q  <= out_pc_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_next_d = pc_next_q;
    instr_d   = instr_q;
    out_pc_d  = out_pc_q;
    valid_d   = valid_q;
    unique case (state_q)
      FETCH: begin
        if (!run_q) begin
          if (in_redirect) pc_d = in_redirect_pc;
        end else if (in_imem_ack) begin
          if (in_redirect) begin
            pc_d = in_redirect_pc;
          end else begin
            instr_d  = in_imem_data;
            out_pc_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + ADDR_W'(1);
            state_d  = HOLD;
          end
        end else if (in_redirect) begin
          pc_next_d = in_redirect_pc;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        // pc_q still holds the stale address the memory is working on.
        if (in_imem_ack) begin
          pc_d    = in_redirect ? in_redirect_pc : pc_next_q;
          state_d = FETCH;
        end else if (in_redirect) begin
          pc_next_d = in_redirect_pc;
        end
      end
      HOLD: begin
        if (in_redirect) begin
          valid_d = 1'b0;
          pc_d    = in_redirect_pc;
          state_d = FETCH;
        end else if (in_dec_ready) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign out_imem_req    = run_q && (state_q != HOLD);
  assign out_imem_addr   = pc_q;
  assign out_instr_valid = valid_q;
  assign out_instr       = instr_q;
  assign out_pc          = out_pc_q;
  assign out_opcode      = valid_q ? instr_q[OPC_MSB -: OPC_W] : OPC_NOP;
  assign out_dbg_state   = state_q;

  ack_only_with_req: assert property (@(posedge in_clk) disable iff (!in_rst_n)
    in_imem_ack |-> out_imem_req);

  addr_stable_until_ack: assert property (@(posedge in_clk) disable iff (!in_rst_n)
    (out_imem_req && !in_imem_ack) |=> $stable(out_imem_addr));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         imem_req;
  logic [15:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_data;
  logic         instr_valid;
  logic         dec_ready;
  logic [31:0]  instr;
  logic [3:0]   opcode;
  logic [15:0]  out_pc;
  logic         redirect;
  logic [15:0]  redirect_pc;
  fetch_state_t dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] seed;

  // model: expected fetch stream, abstracted as "holding a word" / "stale request"
  logic        m_run, m_valid, m_stale;
  logic [15:0] m_addr, m_target, m_pc;
  logic [31:0] m_instr;

  fetch_unit #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(0)) dut (
    .in_clk(clk), .in_rst_n(rst_n),
    .out_imem_req(imem_req), .out_imem_addr(imem_addr),
    .in_imem_ack(imem_ack), .in_imem_data(imem_data),
    .out_instr_valid(instr_valid), .in_dec_ready(dec_ready),
    .out_instr(instr), .out_opcode(opcode), .out_pc(out_pc),
    .in_redirect(redirect), .in_redirect_pc(redirect_pc),
    .out_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hA5C3, ~a} ^ seed;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_valid = 1'b0; m_stale = 1'b0;
    m_addr = RST_PC; m_target = '0; m_pc = '0; m_instr = '0;
  endtask

  // One clock: drive inputs at negedge, advance, update model, return at next negedge.
  task automatic cycle(input logic ack, input logic ready, input logic redir,
                       input logic [15:0] rpc);
    imem_ack    = ack;
    imem_data   = ack ? mem_word(imem_addr) : $urandom();
    dec_ready   = ready;
    redirect    = redir;
    redirect_pc = rpc;
    @(posedge clk);
    if (!m_run) begin
      m_run = 1'b1;
      if (redir) m_addr = rpc;
    end else if (m_valid) begin
      if (redir) begin m_valid = 1'b0; m_addr = rpc; end
      else if (ready) m_valid = 1'b0;
    end else if (ack) begin
      if (m_stale || redir) begin
        m_addr  = redir ? rpc : m_target;
        m_stale = 1'b0;
      end else begin
        m_valid = 1'b1; m_pc = m_addr; m_instr = mem_word(m_addr);
        m_addr  = m_addr + 16'd1;
      end
    end else if (redir) begin
      m_stale = 1'b1; m_target = rpc;
    end
    @(negedge clk);
    imem_ack = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0; dec_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0; dec_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instr !== 32'd0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", instr); end
    n_cmp++; if (opcode !== 4'd0) begin n_fail++; $display("FAIL rst_opcode: got %h want 0", opcode); end
    n_cmp++; if (out_pc !== 16'd0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", out_pc); end
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rel_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL rel_addr: got %h want %h", imem_addr, RST_PC); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] w;
    for (int i = 0; i < 3; i++) begin
      w = mem_word(16'(i));
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'(i)) begin
        n_fail++; $display("FAIL zw_req[%0d]: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, 16'(i)); end
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      n_cmp++; if (instr_valid !== 1'b1 || out_pc !== 16'(i) || imem_req !== 1'b0) begin
        n_fail++; $display("FAIL zw_out[%0d]: got v=%b pc=%h req=%b want v=1 pc=%h req=0", i, instr_valid, out_pc, imem_req, 16'(i)); end
      n_cmp++; if (opcode !== w[31:28] || instr !== w) begin
        n_fail++; $display("FAIL zw_data[%0d]: got op=%h instr=%h want op=%h instr=%h", i, opcode, instr, w[31:28], w); end
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
    end
  endtask

  task automatic test_ack_delay_and_stall();
    logic [31:0] w;
    w = mem_word(16'd3);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'd3 || instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL dly_hold[%0d]: got req=%b addr=%h v=%b want 1/0003/0", k, imem_req, imem_addr, instr_valid); end
      cycle(k == 3, 1'b0, 1'b0, 16'h0);
    end
    n_cmp++; if (instr_valid !== 1'b1 || out_pc !== 16'd3) begin
      n_fail++; $display("FAIL dly_valid: got v=%b pc=%h want v=1 pc=0003", instr_valid, out_pc); end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0);
      n_cmp++; if (instr_valid !== 1'b1 || out_pc !== 16'd3 || instr !== w || opcode !== w[31:28] || imem_req !== 1'b0) begin
        n_fail++; $display("FAIL stall[%0d]: got v=%b pc=%h instr=%h op=%h req=%b want 1/0003/%h/%h/0",
                           k, instr_valid, out_pc, instr, opcode, imem_req, w, w[31:28]); end
    end
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'd4 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got req=%b addr=%h v=%b want 1/0004/0", imem_req, imem_addr, instr_valid); end
  endtask

  task automatic test_redirect_drain();
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    n_cmp++; if (imem_addr !== 16'd5) begin n_fail++; $display("FAIL drn_pre: got addr=%h want 0005", imem_addr); end
    cycle(1'b0, 1'b0, 1'b1, 16'h0040);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'd5 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL drn_stale: got req=%b addr=%h v=%b want 1/0005/0", imem_req, imem_addr, instr_valid); end
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    n_cmp++; if (instr_valid !== 1'b0 || opcode !== 4'd0) begin
      n_fail++; $display("FAIL drn_drop: got v=%b op=%h want 0/0", instr_valid, opcode); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      n_fail++; $display("FAIL drn_target: got req=%b addr=%h want 1/0040", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_hold_and_wrap();
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    n_cmp++; if (instr_valid !== 1'b1 || out_pc !== 16'h0040) begin
      n_fail++; $display("FAIL rh_pre: got v=%b pc=%h want 1/0040", instr_valid, out_pc); end
    cycle(1'b0, 1'b1, 1'b1, 16'h0010);
    n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
      n_fail++; $display("FAIL rh_redir: got v=%b req=%b addr=%h want 0/1/0010", instr_valid, imem_req, imem_addr); end
    cycle(1'b1, 1'b0, 1'b1, 16'hFFFF);
    n_cmp++; if (instr_valid !== 1'b0 || imem_addr !== 16'hFFFF) begin
      n_fail++; $display("FAIL rh_ackredir: got v=%b addr=%h want 0/ffff", instr_valid, imem_addr); end
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    n_cmp++; if (instr_valid !== 1'b1 || out_pc !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_pc: got v=%b pc=%h want 1/ffff", instr_valid, out_pc); end
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_next: got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
    cycle(1'b0, 1'b0, 1'b1, 16'h0020);
    cycle(1'b0, 1'b0, 1'b1, 16'h0030);
    n_cmp++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL drn_hold2: got addr=%h want 0000", imem_addr); end
    cycle(1'b1, 1'b0, 1'b1, 16'h0050);
    n_cmp++; if (imem_addr !== 16'h0050 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL drn_newest: got addr=%h v=%b want 0050/0", imem_addr, instr_valid); end
    cycle(1'b0, 1'b0, 1'b1, 16'h0060);
    cycle(1'b0, 1'b0, 1'b1, 16'h0070);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    n_cmp++; if (imem_addr !== 16'h0070) begin n_fail++; $display("FAIL drn_overwrite: got addr=%h want 0070", imem_addr); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got v=%b want 1", instr_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || opcode !== 4'd0) begin
      n_fail++; $display("FAIL mid_hold_rst: got req=%b v=%b op=%h want 0/0/0", imem_req, instr_valid, opcode); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0033);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      n_fail++; $display("FAIL mid_drain_pre: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || opcode !== 4'd0) begin
      n_fail++; $display("FAIL mid_drain_rst: got req=%b v=%b op=%h want 0/0/0", imem_req, instr_valid, opcode); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      n_fail++; $display("FAIL mid_restart: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC); end
  endtask

  task automatic test_random();
    logic        ack, ready, redir, m_req;
    logic [15:0] rpc;
    for (int c = 0; c < 1500; c++) begin
      m_req = m_run && !m_valid;
      n_cmp++; if (imem_req !== m_req || (m_req && imem_addr !== m_addr)) begin
        n_fail++; $display("FAIL rnd_req[%0d]: got req=%b addr=%h want req=%b addr=%h", c, imem_req, imem_addr, m_req, m_addr); end
      n_cmp++; if (instr_valid !== m_valid) begin
        n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, instr_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (out_pc !== m_pc || instr !== m_instr || opcode !== m_instr[31:28]) begin
          n_fail++; $display("FAIL rnd_out[%0d]: got pc=%h instr=%h op=%h want pc=%h instr=%h op=%h",
                             c, out_pc, instr, opcode, m_pc, m_instr, m_instr[31:28]); end
      end else begin
        n_cmp++; if (opcode !== 4'd0) begin
          n_fail++; $display("FAIL rnd_nop[%0d]: got op=%h want 0", c, opcode); end
      end
      ack   = m_req && ($urandom_range(0, 2) == 0);
      ready = 1'($urandom_range(0, 1));
      redir = m_run && ($urandom_range(0, 9) == 0);
      rpc   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom());
      cycle(ack, ready, redir, rpc);
    end
  endtask

  initial begin
    seed = $urandom();
    rst_n = 1'b0;
    test_reset();
    test_zero_wait();
    test_ack_delay_and_stall();
    test_redirect_drain();
    test_redirect_hold_and_wrap();
    test_reset_mid();
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
